tse_ddr_avalon_slave_responder: RTL and testbench

Single-clock Avalon-MM pipelined slave that terminates the master port of the TSE/DDR clock bridge in block-level and system simulation. It can also stand in for a small on-chip scratch memory. It holds a word-addressed internal memory, returns read data in order after a fixed latency, and limits outstanding reads. It inserts programmable write wait-states, which exercises the bridge's waitrequest-hold logic. It also flags endofpacket on the last word of each aligned packet.

---
 rtl/tse_ddr_avalon_slave_responder.sv | 114 +++++++++++
 tb/tb_tse_ddr_avalon_slave_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/tse_ddr_avalon_slave_responder.sv
// Avalon-MM pipelined slave: word memory, fixed-latency in-order reads,
// bounded outstanding reads, programmable write wait-states, packet-end flag.
module tse_ddr_avalon_slave_responder #(
  parameter int unsigned ADDR_WIDTH        = 6,
  parameter int unsigned READ_LATENCY      = 3,
  parameter int unsigned MAX_PENDING       = 2,
  parameter int unsigned WRITE_WAIT_CYCLES = 1,
  parameter int unsigned PACKET_WORDS      = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [3:0]            byteenable,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           writedata,
  output logic                  waitrequest,
  output logic [31:0]           readdata,
  output logic                  readdatavalid,
  output logic                  endofpacket
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned PW    = $clog2(MAX_PENDING + 1);
  localparam int unsigned LAST  = READ_LATENCY - 1;

  localparam logic [PW-1:0]         PEND_MAX = PW'(MAX_PENDING);
  localparam logic [2:0]            WAIT_MAX = 3'(WRITE_WAIT_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] EOP_MASK = ADDR_WIDTH'(PACKET_WORDS - 1);

  logic [31:0]             r_mem [DEPTH];
  logic [31:0]             r_dat [READ_LATENCY];
  logic [READ_LATENCY-1:0] r_vld;
  logic [READ_LATENCY-1:0] r_eop;
  logic [31:0]             r_rd_hold;
  logic [PW-1:0]           r_pending;
  logic [2:0]              r_wcnt;

  logic                    w_acc_rd;
  logic                    w_acc_wr;
  logic                    w_eop;

  // Read takes priority when both strobes are high; the write is simply ignored.
  always_comb begin
    waitrequest = 1'b0;
    if (!reset_n)
      waitrequest = 1'b1;
    else if (read)
      waitrequest = (r_pending == PEND_MAX);
    else if (write)
      waitrequest = (r_wcnt != WAIT_MAX);
  end

  assign w_acc_rd = read & ~waitrequest;
  assign w_acc_wr = write & ~read & ~waitrequest;
  assign w_eop    = ((address & EOP_MASK) == EOP_MASK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wcnt <= '0;
    end else if (!write || read || w_acc_wr) begin
      r_wcnt <= '0;
    end else begin
      r_wcnt <= r_wcnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
    end else begin
      case ({w_acc_rd, readdatavalid})
        2'b10:   r_pending <= r_pending + PW'(1);
        2'b01:   r_pending <= r_pending - PW'(1);
        default: r_pending <= r_pending;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld     <= '0;
      r_eop     <= '0;
      r_rd_hold <= '0;
    end else begin
      for (int unsigned i = LAST; i > 0; i--) begin
        r_vld[i] <= r_vld[i-1];
        r_eop[i] <= r_eop[i-1];
      end
      r_vld[0] <= w_acc_rd;
      r_eop[0] <= w_acc_rd & w_eop;
      if (r_vld[LAST])
        r_rd_hold <= r_dat[LAST];
    end
  end

  // Memory and read-data stages carry no reset; only the valid tags are cleared.
  always_ff @(posedge clk) begin
    if (w_acc_wr) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (byteenable[b])
          r_mem[address][8*b +: 8] <= writedata[8*b +: 8];
      end
    end
    r_dat[0] <= r_mem[address];
    for (int unsigned i = LAST; i > 0; i--)
      r_dat[i] <= r_dat[i-1];
  end

  assign readdatavalid = r_vld[LAST];
  assign endofpacket   = r_vld[LAST] & r_eop[LAST];
  assign readdata      = r_vld[LAST] ? r_dat[LAST] : r_rd_hold;

endmodule

// File: tb/tb_tse_ddr_avalon_slave_responder.sv
// Directed bench for tse_ddr_avalon_slave_responder with default parameters.
module tb_tse_ddr_avalon_slave_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  address;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        endofpacket;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  int          rv_cyc [$];
  logic [31:0] rv_dat [$];
  logic        rv_eop [$];

  tse_ddr_avalon_slave_responder #(
    .ADDR_WIDTH       (6),
    .READ_LATENCY     (3),
    .MAX_PENDING      (2),
    .WRITE_WAIT_CYCLES(1),
    .PACKET_WORDS     (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address      (address),
    .byteenable   (byteenable),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .waitrequest  (waitrequest),
    .readdata     (readdata),
    .readdatavalid(readdatavalid),
    .endofpacket  (endofpacket)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (readdatavalid) begin
      rv_cyc.push_back(cyc);
      rv_dat.push_back(readdata);
      rv_eop.push_back(endofpacket);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_returns();
    rv_cyc.delete();
    rv_dat.delete();
    rv_eop.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Entered and left at posedge+1; holds the command until accepted.
  task automatic do_cmd(input logic is_rd, input logic is_wr, input logic [5:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        output int acc, output int waits);
    address = a; writedata = d; byteenable = be;
    read = is_rd; write = is_wr;
    acc = -1; waits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!waitrequest) begin
        acc = cyc;
        break;
      end
      waits++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    if (acc < 0) check("cmd_timeout", 32'd0, 32'd1);
  endtask

  int wacc, racc, waits, a0, k;
  int acc_log [$];

  initial begin
    reset_n = 1'b0; address = '0; byteenable = '0;
    read = 1'b0; write = 1'b0; writedata = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_waitreq", 32'(waitrequest), 32'd1);
    check("rst_rdv", 32'(readdatavalid), 32'd0);
    check("rst_rdata", readdata, 32'd0);
    check("rst_eop", 32'(endofpacket), 32'd0);
    reset_n = 1'b1;
    #1;
    check("idle_waitreq", 32'(waitrequest), 32'd0);

    // Write with one wait state, then read back.
    idle(1);
    clear_returns();
    do_cmd(1'b0, 1'b1, 6'd5, 32'hDEADBEEF, 4'hF, wacc, waits);
    check("wr_waits", 32'(waits), 32'd1);
    do_cmd(1'b1, 1'b0, 6'd5, 32'h0, 4'h0, racc, waits);
    check("rd5_waits", 32'(waits), 32'd0);
    idle(6);
    check("rd5_count", 32'(rv_cyc.size()), 32'd1);
    if (rv_cyc.size() == 1) begin
      check("rd5_lat", 32'(rv_cyc[0] - racc), 32'd3);
      check("rd5_data", rv_dat[0], 32'hDEADBEEF);
      check("rd5_eop", 32'(rv_eop[0]), 32'd0);
    end
    check("hold_rdata", readdata, 32'hDEADBEEF);
    check("hold_eop", 32'(endofpacket), 32'd0);

    // Byte lanes: be=0101 updates lanes 0 and 2 only.
    clear_returns();
    do_cmd(1'b0, 1'b1, 6'd7, 32'h11223344, 4'hF, wacc, waits);
    do_cmd(1'b0, 1'b1, 6'd7, 32'hAABBCCDD, 4'b0101, wacc, waits);
    do_cmd(1'b1, 1'b0, 6'd7, 32'h0, 4'h0, racc, waits);
    idle(6);
    check("lane_count", 32'(rv_cyc.size()), 32'd1);
    if (rv_cyc.size() == 1) begin
      check("lane_data", rv_dat[0], 32'h11BB33DD);
      check("lane_eop", 32'(rv_eop[0]), 32'd1);
    end

    // Read and write together act as a read; memory stays untouched.
    clear_returns();
    do_cmd(1'b1, 1'b1, 6'd5, 32'h55555555, 4'hF, racc, waits);
    do_cmd(1'b1, 1'b0, 6'd5, 32'h0, 4'h0, racc, waits);
    idle(6);
    check("rw_count", 32'(rv_cyc.size()), 32'd2);
    if (rv_cyc.size() == 2) begin
      check("rw_data0", rv_dat[0], 32'hDEADBEEF);
      check("rw_data1", rv_dat[1], 32'hDEADBEEF);
    end

    // Back-pressure: six continuous reads of addresses 10..15.
    for (int i = 0; i < 6; i++)
      do_cmd(1'b0, 1'b1, 6'(10 + i), 32'h100 + 32'(i), 4'hF, wacc, waits);
    idle(2);
    clear_returns();
    acc_log.delete();
    k = 0;
    address = 6'd10; read = 1'b1;
    for (int i = 0; i < 40 && k < 6; i++) begin
      @(negedge clk);
      if (!waitrequest) begin
        acc_log.push_back(cyc);
        k++;
      end
      @(posedge clk); #1;
      if (k == 6) read = 1'b0;
      else address = 6'(10 + k);
    end
    read = 1'b0;
    idle(8);
    check("bp_accepts", 32'(acc_log.size()), 32'd6);
    check("bp_returns", 32'(rv_cyc.size()), 32'd6);
    if (acc_log.size() == 6 && rv_cyc.size() == 6) begin
      a0 = acc_log[0];
      check("bp_acc1", 32'(acc_log[1] - a0), 32'd1);
      check("bp_acc2", 32'(acc_log[2] - a0), 32'd4);
      check("bp_acc3", 32'(acc_log[3] - a0), 32'd5);
      check("bp_acc4", 32'(acc_log[4] - a0), 32'd8);
      check("bp_acc5", 32'(acc_log[5] - a0), 32'd9);
      check("bp_rv0", 32'(rv_cyc[0] - a0), 32'd3);
      check("bp_rv1", 32'(rv_cyc[1] - a0), 32'd4);
      check("bp_rv2", 32'(rv_cyc[2] - a0), 32'd7);
      check("bp_rv3", 32'(rv_cyc[3] - a0), 32'd8);
      check("bp_rv4", 32'(rv_cyc[4] - a0), 32'd11);
      check("bp_rv5", 32'(rv_cyc[5] - a0), 32'd12);
      for (int i = 0; i < 6; i++)
        check($sformatf("bp_data%0d", i), rv_dat[i], 32'h100 + 32'(i));
    end

    // Write immediately followed by read of the same word.
    clear_returns();
    do_cmd(1'b0, 1'b1, 6'd3, 32'h1, 4'hF, wacc, waits);
    do_cmd(1'b1, 1'b0, 6'd3, 32'h0, 4'h0, racc, waits);
    idle(6);
    check("wr_rd_gap", 32'(racc - wacc), 32'd1);
    check("wr_rd_count", 32'(rv_cyc.size()), 32'd1);
    if (rv_cyc.size() == 1) begin
      check("wr_rd_cycle", 32'(rv_cyc[0] - wacc), 32'd4);
      check("wr_rd_data", rv_dat[0], 32'h1);
    end

    // Reset with two reads in flight.
    do_cmd(1'b0, 1'b1, 6'd20, 32'hCAFE0020, 4'hF, wacc, waits);
    idle(1);
    clear_returns();
    do_cmd(1'b1, 1'b0, 6'd20, 32'h0, 4'h0, racc, waits);
    do_cmd(1'b1, 1'b0, 6'd3, 32'h0, 4'h0, racc, waits);
    reset_n = 1'b0;
    #1;
    check("mid_rst_waitreq", 32'(waitrequest), 32'd1);
    check("mid_rst_rdata", readdata, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    do_cmd(1'b1, 1'b0, 6'd20, 32'h0, 4'h0, racc, waits);
    check("post_rst_waits", 32'(waits), 32'd0);
    idle(6);
    check("post_rst_count", 32'(rv_cyc.size()), 32'd1);
    if (rv_cyc.size() == 1) begin
      check("post_rst_lat", 32'(rv_cyc[0] - racc), 32'd3);
      check("post_rst_data", rv_dat[0], 32'hCAFE0020);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
